mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the data-memory side of the single-cycle core.
//  Consumes the datapath's store outputs (DataAdr, WriteData, MemWrite).
//  Stores that hit its address window are queued in a small FIFO.
//  Bytes are serialised 8N1, LSB first, on Tx. Status is returned combinationally
//  so loads complete in the same cycle.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  16-byte-aligned base of the register window
//  FIFO_DEPTH   4              TX FIFO entries; power of two, minimum 2
//  DEFAULT_DIV  16'd867        baud divisor at reset; bit time = DIV+1 clocks
// PORTS
//  Clk        in   1   core clock; all state changes on rising edge
//  Reset      in   1   asynchronous, active-low reset
//  MemWrite   in   1   store strobe from control unit
//  DataAdr    in   32  ALU result used as data address
//  WriteData  in   32  store data (RD2)
//  Hit        out  1   DataAdr inside window; steers ReadData mux upstream
//  RdData     out  32  combinational register read data; 0 when !Hit
//  Tx         out  1   serial line, idle high
// BEHAVIOUR
//  Decode and Hit:
//  - Hit = (DataAdr[31:4] == BASE_ADDR[31:4]).
//  - Register select = DataAdr[3:2].
//  Register map:
//  - 0x0 TXDATA (W): push WriteData[7:0]. Reads return 0.
//  - 0x4 STATUS (R): bit0 busy (FSM != IDLE), bit1 full, bit2 empty, bit3 overflow.
//    Upper bits read 0. Writing 1 to bit3 clears overflow.
//  - 0x8 BAUDDIV (R/W): bits [15:0].
//  - 0xC: reserved; reads 0, writes ignored.
//  Writes: take effect at the rising edge where MemWrite & Hit are both high.
//  Reset values:
//  - Tx=1, FIFO empty, overflow=0, DIV=DEFAULT_DIV, FSM=IDLE, bit counter=0.
//  - RdData/Hit are combinational only.
//  FIFO push and pop:
//  - A push when full is dropped and sets overflow (sticky).
//  - Exception: if a pop occurs in the same cycle, the push is accepted and
//    overflow is not set.
//  - Pointers wrap modulo FIFO_DEPTH. Occupancy count is FIFO_DEPTH+1 states wide.
//  FSM states: IDLE, START, DATA, STOP.
//  - IDLE:  Tx=1. If FIFO non-empty: pop into an 8-bit shift register,
//           load baud counter with DIV, go to START. A byte written at edge N
//           drives Tx low from edge N+1.
//  - START: Tx=0 for DIV+1 clocks, then DATA.
//  - DATA:  Tx=shift[0]. Every DIV+1 clocks shift right.
//           After the 8th bit go to STOP.
//  - STOP:  Tx=1 for DIV+1 clocks, then IDLE.
//           The next byte's START begins one clock later (IDLE pop cycle).
//  Baud counter:
//  - Counts down from DIV to 0, then reloads.
//  - A BAUDDIV write mid-frame applies at the next reload, never truncating the
//    current bit.
//  - DIV=0 gives 1 clock per bit.
//  Boundary cases:
//  - Write during busy only enqueues; the frame in flight is unaffected.
//  - Reset mid-frame forces Tx=1 immediately and discards the FIFO contents.
//  - STATUS bit0 is high from the IDLE->START edge until STOP->IDLE.
// STRUCTURE
//  - Shared package riscv_mmio_pkg holds:
//    - register offsets (OFF_TXDATA/STATUS/BAUDDIV)
//    - STATUS bit indices
//    - the FSM state encoding (2-bit localparams).
//  - One sub-module: uart_tx_fifo (sync FIFO; push/pop/full/empty/count).
//  - The top holds decode, registers, baud counter and FSM.
// TESTING
//  1. Reset low mid-frame -> Tx=1 same cycle.
//     After release: STATUS=0x4, BAUDDIV reads 867.
//  2. DIV=3, store 0xA5 to 0x1000 -> Tx low 4 clocks from next edge.
//     Then bits 1,0,1,0,0,1,0,1 at 4 clocks each, stop 4 clocks.
//     Busy for 40 clocks.
//  3. DIV=1, 6 back-to-back stores:
//     - 1st byte popped immediately, next 4 fill the FIFO (full=1).
//     - 6th store dropped, overflow=1.
//     - Write 0x8 to STATUS -> overflow=0.
//  4. Store to 0x1000 on the exact cycle the FSM pops from a full FIFO
//     -> byte accepted, overflow stays 0, all 5 bytes transmitted in order.
//  5. DIV=3 frame running; write DIV=7 during a DATA bit
//     -> current bit lasts 4 clocks, following bits last 8.
//  6. Load at 0x2004 -> Hit=0, RdData=0.
//     Store to 0x100C -> no state change.

Source files
------------

// File: rtl/riscv_mmio_pkg.sv
// Shared constants for the memory-mapped peripherals on the data-memory side of the core:
// register word offsets, STATUS bit positions and the UART transmit FSM encoding.
package riscv_mmio_pkg;

    // Register select values, i.e. DataAdr[3:2]
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for transmit bytes: write visible one cycle after push, pop data is the head (fall-through).
// Push is accepted when not full or when a pop happens in the same cycle; pop on empty is ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        // A simultaneous pop frees the slot this push needs
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register reads are combinational, a byte stored at edge N drives Tx low from N+1.
// Stores never stall the core; a store to a full FIFO is dropped and flagged in the sticky overflow bit.
module mmio_uart_tx
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        Hit,
    output logic [31:0] RdData,
    output logic        Tx
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]    sel;
    logic          wr_en, push, pop, busy, baud_done;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dat;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    logic [1:0]  state_q, state_d;
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        ovf_q, ovf_d;

    logic unused_ok;
    assign unused_ok = ^{WriteData[31:16], DataAdr[1:0], fifo_count};

    assign Hit       = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign sel       = DataAdr[3:2];
    assign wr_en     = MemWrite && Hit;
    assign push      = wr_en && (sel == OFF_TXDATA);
    assign pop       = (state_q == S_IDLE) && !fifo_empty;
    assign busy      = (state_q != S_IDLE);
    assign baud_done = (cnt_q == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk      (Clk),
        .rst_n    (Reset),
        .push     (push),
        .push_dat (WriteData[7:0]),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf_q;
        RdData           = '0;
        if (Hit) begin
            case (sel)
                OFF_STATUS:  RdData = status;
                OFF_BAUDDIV: RdData = {16'd0, div_q};
                default:     RdData = '0;
            endcase
        end
    end

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_en && (sel == OFF_BAUDDIV)) begin
            div_d = WriteData[15:0];
        end
        if (wr_en && (sel == OFF_STATUS) && WriteData[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // The baud counter reloads from div_q, so a new divisor only lands at a bit boundary
    always_comb begin
        state_d = state_q;
        cnt_d   = baud_done ? div_q : cnt_q - 16'd1;
        shift_d = shift_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (pop) begin
                    state_d = S_START;
                    shift_d = fifo_dat;
                    cnt_d   = div_q;
                end
            end
            S_START: begin
                if (baud_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_done) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                if (baud_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_START: Tx = 1'b0;
            S_DATA:  Tx = shift_q[0];
            default: Tx = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            div_q   <= DEFAULT_DIV;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a serial-line receiver pops expected bytes from a scoreboard queue,
// while scenario tasks check register reads and cycle-exact Tx/busy timing.
module tb_mmio_uart_tx;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        Hit;
    logic [31:0] RdData;
    logic        Tx;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;
    int         mon_div = 3;

    mmio_uart_tx dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Hit       (Hit),
        .RdData    (RdData),
        .Tx        (Tx)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Serial receiver: samples each bit in its middle using the divisor the bench configured
    bit         rx_act = 1'b0;
    int         rx_k = 0;
    int         rx_b = 4;
    int         rx_m = 2;
    logic [7:0] rx_byte = 8'd0;
    logic [7:0] rx_exp = 8'd0;

    always @(negedge Clk) begin
        if (!Reset || !mon_en) begin
            rx_act = 1'b0;
        end else begin
            rx_b = mon_div + 1;
            rx_m = rx_b / 2;
            if (!rx_act) begin
                if (Tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_k   = 0;
                end
            end else begin
                rx_k++;
            end
            if (rx_act) begin
                if (rx_k == rx_m) begin
                    checks++;
                    if (Tx !== 1'b0) begin
                        failures++;
                        $display("FAIL rx_start_bit got=%b exp=0", Tx);
                    end
                end
                for (int i = 0; i < 8; i++) begin
                    if (rx_k == rx_b * (i + 1) + rx_m) rx_byte[i] = Tx;
                end
                if (rx_k == rx_b * 9 + rx_m) begin
                    checks++;
                    if (Tx !== 1'b1) begin
                        failures++;
                        $display("FAIL rx_stop_bit got=%b exp=1", Tx);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rx_unexpected_byte got=%02h exp=none", rx_byte);
                    end else begin
                        rx_exp = exp_q.pop_front();
                        if (rx_byte !== rx_exp) begin
                            failures++;
                            $display("FAIL rx_byte got=%02h exp=%02h", rx_byte, rx_exp);
                        end
                    end
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        MemWrite = 1'b0;
        DataAdr  = a;
        #1;
        d = RdData;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bit bad;
        #3 Reset = 1'b0;
        #1;
        checks++;
        if (Tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", Tx); end
        repeat (3) tick();
        Reset = 1'b1;
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'h4) begin failures++; $display("FAIL reset_status got=%0h exp=4", rd); end
        bus_read(32'h1008, rd);
        checks++;
        if (rd !== 32'd867) begin failures++; $display("FAIL reset_baud got=%0d exp=867", rd); end

        // Start a frame with bytes queued behind it, then reset during the start bit
        bus_write(32'h1008, 32'd3);
        bus_write(32'h1000, 32'h3C);
        bus_write(32'h1000, 32'h5A);
        bus_write(32'h1000, 32'h66);
        checks++;
        if (Tx !== 1'b0) begin failures++; $display("FAIL midframe_tx_low got=%b exp=0", Tx); end
        Reset = 1'b0;
        #1;
        checks++;
        if (Tx !== 1'b1) begin failures++; $display("FAIL midframe_reset_tx got=%b exp=1", Tx); end
        tick();
        Reset = 1'b1;
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'h4) begin failures++; $display("FAIL midframe_reset_status got=%0h exp=4", rd); end
        bus_read(32'h1008, rd);
        checks++;
        if (rd !== 32'd867) begin failures++; $display("FAIL midframe_reset_baud got=%0d exp=867", rd); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Tx !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL fifo_discarded_tx got=0 exp=1"); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [9:0]  fr;
        logic        exp_tx;
        fr = {1'b1, 8'hA5, 1'b0};
        bus_write(32'h1008, 32'd3);
        mon_div = 3;
        mon_en  = 1'b1;
        exp_q.push_back(8'hA5);
        bus_write(32'h1000, 32'hA5);
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'h0 || Tx !== 1'b1) begin
            failures++;
            $display("FAIL frame_pre_start status=%0h tx=%b exp status=0 tx=1", rd, Tx);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            bus_read(32'h1004, rd);
            exp_tx = fr[c / 4];
            checks++;
            if (Tx !== exp_tx || rd[0] !== 1'b1) begin
                failures++;
                $display("FAIL frame_cycle c=%0d tx=%b busy=%b exp tx=%b busy=1", c, Tx, rd[0], exp_tx);
            end
        end
        tick();
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'h4 || Tx !== 1'b1) begin
            failures++;
            $display("FAIL frame_end status=%0h tx=%b exp status=4 tx=1", rd, Tx);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bus_write(32'h1008, 32'd1);
        mon_div = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'(8'h11 + i));
            bus_write(32'h1000, 32'(8'h11 + i));
        end
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'hB) begin failures++; $display("FAIL overflow_status got=%0h exp=b", rd); end
        bus_write(32'h1004, 32'h8);
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'h3) begin failures++; $display("FAIL overflow_clear got=%0h exp=3", rd); end
    endtask

    task automatic test_pop_push_full();
        logic [31:0] rd;
        bit found;
        bit drained;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            bus_read(32'h1004, rd);
            if (rd[0] == 1'b0 && rd[1] == 1'b1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL pop_full_wait got=timeout exp=idle_and_full");
        end else begin
            exp_q.push_back(8'h77);
            bus_write(32'h1000, 32'h77);
            bus_read(32'h1004, rd);
            checks++;
            if (rd !== 32'h3) begin failures++; $display("FAIL pop_push_status got=%0h exp=3", rd); end
        end
        drained = 1'b0;
        for (int i = 0; i < 400 && !drained; i++) begin
            tick();
            bus_read(32'h1004, rd);
            if (rd == 32'h4) drained = 1'b1;
        end
        checks++;
        if (!drained) begin failures++; $display("FAIL drain_wait got=%0h exp=4", rd); end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_bytes_left got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_div_change();
        logic [31:0] rd;
        logic [9:0]  fr;
        logic        exp_tx;
        int          idx;
        fr = {1'b1, 8'h55, 1'b0};
        bus_write(32'h1008, 32'd3);
        mon_en = 1'b0;
        bus_write(32'h1000, 32'h55);
        for (int c = 0; c < 72; c++) begin
            if (c == 5) begin
                MemWrite  = 1'b1;
                DataAdr   = 32'h1008;
                WriteData = 32'd7;
            end
            tick();
            MemWrite = 1'b0;
            bus_read(32'h1004, rd);
            if (c < 4) idx = 0;
            else if (c < 8) idx = 1;
            else if (c < 64) idx = (c - 8) / 8 + 2;
            else idx = 9;
            exp_tx = fr[idx];
            checks++;
            if (Tx !== exp_tx || rd[0] !== 1'b1) begin
                failures++;
                $display("FAIL div_change_cycle c=%0d tx=%b busy=%b exp tx=%b busy=1", c, Tx, rd[0], exp_tx);
            end
        end
        tick();
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'h4 || Tx !== 1'b1) begin
            failures++;
            $display("FAIL div_change_end status=%0h tx=%b exp status=4 tx=1", rd, Tx);
        end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        bus_read(32'h2004, rd);
        checks++;
        if (Hit !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL miss_read hit=%b data=%0h exp hit=0 data=0", Hit, rd);
        end
        bus_read(32'h1000, rd);
        checks++;
        if (Hit !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL txdata_read hit=%b data=%0h exp hit=1 data=0", Hit, rd);
        end
        bus_read(32'h100C, rd);
        checks++;
        if (Hit !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL reserved_read hit=%b data=%0h exp hit=1 data=0", Hit, rd);
        end
        bus_write(32'h100C, 32'hFFFF_FFFF);
        bus_write(32'h2000, 32'hAB);
        tick();
        bus_read(32'h1004, rd);
        checks++;
        if (rd !== 32'h4 || Tx !== 1'b1) begin
            failures++;
            $display("FAIL ignored_write_status status=%0h tx=%b exp status=4 tx=1", rd, Tx);
        end
        bus_read(32'h1008, rd);
        checks++;
        if (rd !== 32'd7) begin failures++; $display("FAIL ignored_write_baud got=%0d exp=7", rd); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_pop_push_full();
        test_div_change();
        test_decode();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
